// File: rtl/rx_word_aligner.sv
// rx_word_aligner: comma-based 10-bit word alignment of a sliced serial bit stream.
// Optional feature macro RX_ALIGNER_STATUS_EN adds the comma_err_cnt status output.
module rx_word_aligner #(
   parameter int LOCK_CNT  = 3,
   parameter int ERR_LIMIT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       serial_in,
   output logic [9:0] data_out,
   output logic       data_valid,
   output logic       comma_det,
`ifdef RX_ALIGNER_STATUS_EN
   output logic [7:0] comma_err_cnt,
`endif
   output logic       aligned
);
   localparam logic [7:0] LOCK_MAX = 8'(LOCK_CNT);
   localparam logic [7:0] ERR_MAX  = 8'(ERR_LIMIT);
   localparam logic [9:0] COMMA_P  = 10'b0011111010;
   localparam logic [9:0] COMMA_N  = 10'b1100000101;

   typedef enum logic [1:0] {SEARCH, LOCKING, LOCKED} state_t;

   state_t     state, state_nx;
   logic [9:0] sr, w, data_nx;
   logic [3:0] fill, bit_cnt, bit_nx;
   logic [7:0] lock_cnt, lock_nx, err_cnt, err_nx;
   logic       valid_nx, comma_nx, comma, boundary, unused_sr_msb;

   // The window already contains the bit arriving on this edge, so a word is
   // recognised on the same edge its last bit is sampled.
   assign w             = {sr[8:0], serial_in};
   assign comma         = (fill == 4'd9) && ((w == COMMA_P) || (w == COMMA_N));
   assign boundary      = bit_cnt == 4'd9;
   assign unused_sr_msb = sr[9];

   // Next-state, counter and output decode for the alignment FSM
   always_comb begin
      state_nx = state;
      bit_nx   = boundary ? 4'd0 : bit_cnt + 4'd1;
      lock_nx  = lock_cnt;
      err_nx   = err_cnt;
      data_nx  = data_out;
      valid_nx = 1'b0;
      comma_nx = 1'b0;
      case (state)
         SEARCH: begin
            bit_nx = bit_cnt;
            if (comma) begin
               data_nx  = w;
               valid_nx = 1'b1;
               comma_nx = 1'b1;
               bit_nx   = 4'd0;
               lock_nx  = 8'd1;
               state_nx = (LOCK_MAX <= 8'd1) ? LOCKED : LOCKING;
            end
         end
         LOCKING: begin
            if (boundary) begin
               data_nx  = w;
               valid_nx = 1'b1;
               comma_nx = comma;
               if (comma) begin
                  lock_nx  = lock_cnt + 8'd1;
                  state_nx = (lock_cnt + 8'd1 >= LOCK_MAX) ? LOCKED : LOCKING;
               end
            end else if (comma) begin
               data_nx  = w;
               valid_nx = 1'b1;
               comma_nx = 1'b1;
               bit_nx   = 4'd0;
               lock_nx  = 8'd1;
            end
         end
         LOCKED: begin
            if (boundary) begin
               data_nx  = w;
               valid_nx = 1'b1;
               comma_nx = comma;
               err_nx   = comma ? 8'd0 : err_cnt;
            end else if (comma) begin
               err_nx = err_cnt + 8'd1;
               if (err_cnt + 8'd1 >= ERR_MAX) begin
                  state_nx = SEARCH;
                  err_nx   = 8'd0;
                  lock_nx  = 8'd0;
               end
            end
         end
         default: state_nx = SEARCH;
      endcase
   end

   // Shift register, fill guard, FSM state and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sr         <= '0;
         fill       <= '0;
         bit_cnt    <= '0;
         lock_cnt   <= '0;
         err_cnt    <= '0;
         state      <= SEARCH;
         data_out   <= '0;
         data_valid <= 1'b0;
         comma_det  <= 1'b0;
         aligned    <= 1'b0;
      end else begin
         sr         <= w;
         fill       <= (fill == 4'd9) ? fill : fill + 4'd1;
         bit_cnt    <= bit_nx;
         lock_cnt   <= lock_nx;
         err_cnt    <= err_nx;
         state      <= state_nx;
         data_out   <= data_nx;
         data_valid <= valid_nx;
         comma_det  <= comma_nx;
         aligned    <= state_nx == LOCKED;
      end
   end

`ifdef RX_ALIGNER_STATUS_EN
   // Lifetime count of misaligned commas seen while locked; only reset clears it
   always_ff @(posedge clk) begin
      if (!rst_n)
         comma_err_cnt <= '0;
      else if (state == LOCKED && comma && !boundary && comma_err_cnt != 8'hFF)
         comma_err_cnt <= comma_err_cnt + 8'd1;
   end
`endif
endmodule

// File: tb/tb_rx_word_aligner.sv
// tb_rx_word_aligner: scoreboard bench for rx_word_aligner (default LOCK_CNT=3, ERR_LIMIT=2).
module tb_rx_word_aligner;
   localparam logic [9:0] C  = 10'b0011111010;
   localparam logic [9:0] CN = 10'b1100000101;

   typedef struct {
      int         edge_no;
      logic [9:0] data;
      logic       comma;
      logic       al;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       serial_in = 1'b0;
   logic [9:0] data_out;
   logic       data_valid, comma_det, aligned;
`ifdef RX_ALIGNER_STATUS_EN
   logic [7:0] comma_err_cnt;
`endif

   exp_t sb[$];
   int   n_edge = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   rx_word_aligner dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .serial_in  (serial_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .comma_det  (comma_det),
`ifdef RX_ALIGNER_STATUS_EN
      .comma_err_cnt (comma_err_cnt),
`endif
      .aligned    (aligned)
   );

   initial forever #5 clk = ~clk;

   // Every emitted word must match the oldest expectation, including the edge it belongs to
   always @(negedge clk) begin
      if (data_valid !== 1'b0) begin
         exp_t e;
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_word: got valid=%b data=%h at edge %0d, required no word", data_valid, data_out, n_edge);
         end else begin
            e = sb.pop_front();
            if (n_edge !== e.edge_no || data_out !== e.data || comma_det !== e.comma || aligned !== e.al) begin
               n_fail++;
               $display("FAIL word: got edge=%0d data=%h comma=%b aligned=%b, required edge=%0d data=%h comma=%b aligned=%b",
                        n_edge, data_out, comma_det, aligned, e.edge_no, e.data, e.comma, e.al);
            end
         end
      end
   end

   task automatic tick(input logic b);
      serial_in = b;
      @(posedge clk);
      n_edge++;
      #1;
   endtask

   task automatic push(input logic [9:0] d, input logic c, input logic a);
      exp_t e;
      e.edge_no = n_edge;
      e.data    = d;
      e.comma   = c;
      e.al      = a;
      sb.push_back(e);
   endtask

   task automatic send_word(input logic [9:0] w);
      for (int i = 9; i >= 0; i--) tick(w[i]);
   endtask

   // Send w; the word boundary falls right after bit w[at], where d is expected
   task automatic send_split(input logic [9:0] w, input int at, input logic [9:0] d, input logic c, input logic a);
      for (int i = 9; i >= 0; i--) begin
         tick(w[i]);
         if (i == at) push(d, c, a);
      end
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      tick(1'b0);
      rst_n = 1'b1;
   endtask

   task automatic drain(input string name);
      @(negedge clk);
      #1;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL %s_missing_words: got %0d words outstanding, required 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) tick(1'($urandom_range(1)));
      n_checks++;
      if ({data_out, data_valid, comma_det, aligned} !== 13'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got data=%h valid=%b comma=%b aligned=%b, required all 0", data_out, data_valid, comma_det, aligned);
      end
`ifdef RX_ALIGNER_STATUS_EN
      n_checks++;
      if (comma_err_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_err_cnt: got %0d, required 0", comma_err_cnt);
      end
`endif
      rst_n = 1'b1;
   endtask

   task automatic test_fill;
      logic [7:0] part = 8'b11111010;
      do_reset;
      for (int i = 7; i >= 0; i--) tick(part[i]);
      repeat (20) tick(1'b0);
      drain("fill");
      n_checks++;
      if (aligned !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_aligned: got %b, required 0", aligned);
      end
   endtask

   task automatic test_lock;
      do_reset;
      for (int k = 0; k < 4; k++) begin
         send_word(C);
         push(C, 1'b1, k >= 2);
      end
      drain("lock");
      n_checks++;
      if (aligned !== 1'b1) begin
         n_fail++;
         $display("FAIL lock_aligned: got %b, required 1", aligned);
      end
   endtask

   task automatic test_data;
      send_word(10'h155);
      push(10'h155, 1'b0, 1'b1);
      send_word(CN);
      push(CN, 1'b1, 1'b1);
      send_word(C);
      push(C, 1'b1, 1'b1);
      drain("data");
      n_checks++;
      if (aligned !== 1'b1) begin
         n_fail++;
         $display("FAIL data_aligned: got %b, required 1", aligned);
      end
   endtask

   task automatic test_misalign;
      repeat (3) tick(1'b0);
      send_split(C, 3, 10'h01F, 1'b0, 1'b1);
      n_checks++;
      if (aligned !== 1'b1) begin
         n_fail++;
         $display("FAIL misalign_first: got aligned=%b, required 1", aligned);
      end
      send_split(C, 3, 10'h11F, 1'b0, 1'b1);
      drain("misalign");
      n_checks++;
      if (aligned !== 1'b0) begin
         n_fail++;
         $display("FAIL misalign_second: got aligned=%b, required 0", aligned);
      end
`ifdef RX_ALIGNER_STATUS_EN
      n_checks++;
      if (comma_err_cnt !== 8'd2) begin
         n_fail++;
         $display("FAIL misalign_err_cnt: got %0d, required 2", comma_err_cnt);
      end
`endif
   endtask

   task automatic test_research;
      for (int k = 0; k < 3; k++) begin
         send_word(C);
         push(C, 1'b1, k == 2);
      end
      drain("research");
`ifdef RX_ALIGNER_STATUS_EN
      n_checks++;
      if (comma_err_cnt !== 8'd2) begin
         n_fail++;
         $display("FAIL research_err_cnt: got %0d, required 2", comma_err_cnt);
      end
`endif
   endtask

   task automatic test_err_clear;
      for (int k = 0; k < 2; k++) begin
         repeat (3) tick(1'b0);
         send_split(C, 3, 10'h01F, 1'b0, 1'b1);
         repeat (7) tick(1'b0);
         push(10'h100, 1'b0, 1'b1);
         send_word(C);
         push(C, 1'b1, 1'b1);
      end
      drain("err_clear");
      n_checks++;
      if (aligned !== 1'b1) begin
         n_fail++;
         $display("FAIL err_clear_aligned: got %b, required 1", aligned);
      end
`ifdef RX_ALIGNER_STATUS_EN
      n_checks++;
      if (comma_err_cnt !== 8'd4) begin
         n_fail++;
         $display("FAIL err_clear_err_cnt: got %0d, required 4", comma_err_cnt);
      end
`endif
   endtask

   task automatic test_realign;
      do_reset;
      send_word(C);
      push(C, 1'b1, 1'b0);
      send_word(C);
      push(C, 1'b1, 1'b0);
      tick(1'b0);
      send_split(C, 1, 10'h07D, 1'b0, 1'b0);
      push(C, 1'b1, 1'b0);
      send_word(C);
      push(C, 1'b1, 1'b0);
      send_word(C);
      push(C, 1'b1, 1'b1);
      drain("realign");
   endtask

   task automatic test_reset_locked;
      do_reset;
      for (int k = 0; k < 3; k++) begin
         send_word(C);
         push(C, 1'b1, k == 2);
      end
      for (int i = 9; i >= 5; i--) tick(C[i]);
      n_checks++;
      if (aligned !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_locked_pre: got aligned=%b, required 1", aligned);
      end
      rst_n = 1'b0;
      tick(1'b1);
      n_checks++;
      if ({data_out, data_valid, comma_det, aligned} !== 13'b0) begin
         n_fail++;
         $display("FAIL reset_locked_outputs: got data=%h valid=%b comma=%b aligned=%b, required all 0", data_out, data_valid, comma_det, aligned);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         send_word(C);
         push(C, 1'b1, k == 2);
      end
      drain("reset_locked");
   endtask

   initial begin
      test_reset;
      test_fill;
      test_lock;
      test_data;
      test_misalign;
      test_research;
      test_err_clear;
      test_realign;
      test_reset_locked;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/rx_word_aligner.md
RX_WORD_ALIGNER -- requirements
Module: rx_word_aligner

Interface
REQ-001 Parameter LOCK_CNT, default 3: number of boundary-aligned commas needed to declare lock.
REQ-002 Parameter ERR_LIMIT, default 2: number of consecutive misaligned commas in LOCKED that forces re-search.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-005 serial_in  input  1  sliced bit from the equalizer output, one bit per clk.
REQ-006 data_out  output  10  aligned 10-bit word; first-received bit in data_out[9].
REQ-007 data_valid  output  1  one-cycle pulse when data_out carries a new word.
REQ-008 comma_det  output  1  high together with data_valid when data_out is a comma.
REQ-009 aligned  output  1  high while the FSM is in LOCKED.

Function
REQ-010 The block SHALL shift serial_in into a 10-bit register on every posedge: sr <= {sr[8:0], serial_in}.
REQ-011 The block SHALL evaluate the window W = {sr[8:0], serial_in} at each posedge.
REQ-012 W is a comma iff W equals 10'b0011111010 or 10'b1100000101.
REQ-013 Comma detection SHALL be suppressed until 10 bits have been sampled since reset, tracked by a saturating fill counter.
REQ-014 The FSM SHALL have three states: SEARCH, LOCKING and LOCKED.
REQ-015 A 4-bit bit_cnt SHALL mark the word boundary: an edge with bit_cnt==9 is a boundary edge and sets bit_cnt to 0; other edges increment it.
REQ-016 SEARCH, comma in W: the block SHALL set data_out<=W, data_valid<=1, comma_det<=1, bit_cnt<=0 and lock_cnt<=1, and move to LOCKING (or directly to LOCKED if LOCK_CNT==1).
REQ-017 SEARCH, no comma: data_valid SHALL stay 0 and bit_cnt SHALL be held.
REQ-018 LOCKING/LOCKED, every boundary edge: the block SHALL set data_out<=W and data_valid<=1, with comma_det<=1 iff W is a comma.
REQ-019 LOCKING, comma at a boundary edge: lock_cnt SHALL increment; on reaching LOCK_CNT the FSM SHALL enter LOCKED.
REQ-020 LOCKING, non-comma word at a boundary edge: lock_cnt SHALL be unchanged.
REQ-021 LOCKING, comma at a non-boundary edge (realign): the block SHALL set bit_cnt<=0 and lock_cnt<=1, emit W with data_valid=1 and comma_det=1, and stay in LOCKING.
REQ-022 LOCKED, comma at a non-boundary edge: err_cnt SHALL increment and no word SHALL be emitted.
REQ-023 LOCKED, err_cnt reaching ERR_LIMIT: the FSM SHALL go to SEARCH, clearing err_cnt and lock_cnt.
REQ-024 LOCKED, comma at a boundary edge: err_cnt SHALL be cleared.
REQ-025 All outputs SHALL be registered.
REQ-026 Latency: data_out/data_valid SHALL appear one cycle after the last bit of the word is sampled.
REQ-027 data_valid SHALL never be high on two consecutive cycles, except on a LOCKING realign.
REQ-028 aligned SHALL be the registered decode of state==LOCKED.

Reset
REQ-029 When rst_n=0 at a posedge, the block SHALL set: sr=0, fill counter=0, bit_cnt=0, lock_cnt=0, err_cnt=0, state=SEARCH, data_out=0, data_valid=0, comma_det=0, aligned=0.
REQ-030 A reset asserted mid-word or in LOCKED SHALL discard the partial word, with no data_valid on the reset edge.

Configuration
REQ-031 Macro RX_ALIGNER_STATUS_EN defined: the block SHALL add output comma_err_cnt[7:0], counting every misaligned comma seen in LOCKED.
REQ-032 comma_err_cnt SHALL saturate at 255, be cleared only by reset, and not be cleared by re-search.
REQ-033 Macro RX_ALIGNER_STATUS_EN undefined: the port and its counter SHALL be absent, with all other behaviour identical.

Verification
REQ-034 Reset; stream 0011111010 repeated 4 times -> valid pulses 1, 11, 21, 31 cycles after the first comma's last bit; aligned rises on the 3rd comma; comma_det=1 on every pulse.
REQ-035 Reset; 8 bits 11111010 only, then idle zeros -> no data_valid, because the fill guard suppresses the false match with reset zeros.
REQ-036 In LOCKED, word 0x155 at a boundary -> data_out=0x155, data_valid=1, comma_det=0, aligned stays 1.
REQ-037 In LOCKED, inject two commas shifted by 3 bits with no aligned comma between -> aligned falls after the 2nd; with the macro defined, comma_err_cnt=2.
REQ-038 In LOCKING after 2 commas, one comma shifted by 1 bit -> realign; lock_cnt restarts at 1 and 2 more aligned commas are needed to set aligned.
REQ-039 rst_n low for 1 cycle while LOCKED mid-word -> all outputs 0 on the next cycle; relock requires LOCK_CNT fresh commas.
